// File: rtl/ahb_master.sv
// AHB-Lite burst master: converts a single command into a pipelined
// INCR burst of word transfers, honouring wait states and ERROR aborts.
module ahb_master (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    output logic        wr_req,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DRAIN,
        S_ERR
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    state_t     state;
    logic [3:0] cnt;
    // A data phase is outstanding on the bus.
    logic       dp;
    logic       rd_ok;
    logic       err_first;

    assign cmd_ready = (state == S_IDLE);
    assign wr_req    = (state == S_ADDR) & HWRITE & HREADY;
    assign HSIZE     = 3'b010;
    assign rd_ok     = dp & ~HWRITE & HREADY & ~HRESP;
    assign err_first = dp & HRESP & ~HREADY;

    // Burst sequencer: address/control, write data and read capture.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            dp       <= 1'b0;
            HADDR    <= 32'd0;
            HTRANS   <= TR_IDLE;
            HWRITE   <= 1'b0;
            HBURST   <= 3'b000;
            HWDATA   <= 32'd0;
            rd_data  <= 32'd0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            if (rd_ok) begin
                rd_data  <= HRDATA;
                rd_valid <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    HTRANS <= TR_IDLE;
                    if (cmd_valid) begin
                        HADDR  <= {cmd_addr[31:2], 2'b00};
                        HWRITE <= cmd_write;
                        HBURST <= (cmd_len == 4'd0) ? 3'b000 : 3'b001;
                        HTRANS <= TR_NONSEQ;
                        cnt    <= cmd_len;
                        state  <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (err_first) begin
                        HTRANS <= TR_IDLE;
                        state  <= S_ERR;
                    end else if (HREADY) begin
                        dp    <= 1'b1;
                        HADDR <= HADDR + 32'd4;
                        if (HWRITE) begin
                            HWDATA <= wr_data;
                        end
                        if (cnt == 4'd0) begin
                            HTRANS <= TR_IDLE;
                            state  <= S_DRAIN;
                        end else begin
                            cnt <= cnt - 4'd1;
                            // A beat landing on a 1 KB boundary restarts as NONSEQ.
                            HTRANS <= (HADDR[9:2] == 8'hFF) ? TR_NONSEQ : TR_SEQ;
                        end
                    end
                end
                S_DRAIN: begin
                    if (err_first) begin
                        state <= S_ERR;
                    end else if (HREADY) begin
                        done  <= 1'b1;
                        dp    <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_ERR: begin
                    if (HREADY) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        dp    <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_master.sv
// Directed bench for ahb_master: the bench plays the AHB slave and checks
// every cycle against hand-computed bus and handshake values.
module tb_ahb_master;

    logic        HCLK;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        wr_req;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int n_chk  = 0;
    int n_fail = 0;

    ahb_master dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic w, input logic [31:0] a,
                       input logic [3:0] l);
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
    endtask

    // One bus cycle: drive slave/local inputs at the falling edge, then check.
    task automatic cyc(input logic cv, input logic hr, input logic hs,
                       input logic [31:0] rdat, input logic [31:0] wdat,
                       input logic [1:0] et, input logic [31:0] ea,
                       input logic rv, input logic [31:0] rd,
                       input logic dn, input logic er);
        @(negedge HCLK);
        cmd_valid = cv;
        HREADY    = hr;
        HRESP     = hs;
        HRDATA    = rdat;
        wr_data   = wdat;
        #1;
        chk("htrans", 32'(HTRANS), 32'(et));
        if (et != 2'b00) chk("haddr", HADDR, ea);
        chk("rd_valid", 32'(rd_valid), 32'(rv));
        if (rv) chk("rd_data", rd_data, rd);
        chk("done", 32'(done), 32'(dn));
        chk("err", 32'(err), 32'(er));
    endtask

    initial begin
        HRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'd0;
        cmd_len   = 4'd0;
        wr_data   = 32'd0;
        HRDATA    = 32'd0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;

        // Reset state
        @(negedge HCLK);
        #1;
        chk("rst_htrans", 32'(HTRANS), 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", 32'(HWRITE), 32'h0);
        chk("rst_hburst", 32'(HBURST), 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("rst_hsize", 32'(HSIZE), 32'h2);

        // Single write, zero wait; low address bits are dropped
        cmd(1'b1, 32'h103, 4'd0);
        cyc(0, 1, 0, 0, 32'hDEADBEEF, 2'b10, 32'h100, 0, 0, 0, 0);
        chk("w1_hburst", 32'(HBURST), 32'h0);
        chk("w1_hwrite", 32'(HWRITE), 32'h1);
        chk("w1_wr_req", 32'(wr_req), 32'h1);
        chk("w1_cmd_ready", 32'(cmd_ready), 32'h0);
        cyc(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        chk("w1_hwdata", HWDATA, 32'hDEADBEEF);
        cyc(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
        chk("w1_cmd_ready_done", 32'(cmd_ready), 32'h1);

        // 4-beat read with one wait state
        cmd(1'b0, 32'h200, 4'd3);
        cyc(0, 1, 0, 0, 0, 2'b10, 32'h200, 0, 0, 0, 0);
        chk("r4_hburst", 32'(HBURST), 32'h1);
        chk("r4_wr_req", 32'(wr_req), 32'h0);
        cyc(0, 0, 0, 32'hBAD0BAD0, 0, 2'b11, 32'h204, 0, 0, 0, 0);
        cyc(0, 1, 0, 32'hA0000000, 0, 2'b11, 32'h204, 0, 0, 0, 0);
        cyc(0, 1, 0, 32'hA1111111, 0, 2'b11, 32'h208, 1, 32'hA0000000, 0, 0);
        cyc(0, 1, 0, 32'hA2222222, 0, 2'b11, 32'h20C, 1, 32'hA1111111, 0, 0);
        cyc(0, 1, 0, 32'hA3333333, 0, 2'b00, 0, 1, 32'hA2222222, 0, 0);
        cyc(0, 1, 0, 0, 0, 2'b00, 0, 1, 32'hA3333333, 1, 0);

        // 1 KB boundary crossing write
        cmd(1'b1, 32'h3F8, 4'd3);
        cyc(0, 1, 0, 0, 32'h11111111, 2'b10, 32'h3F8, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 32'h22222222, 2'b11, 32'h3FC, 0, 0, 0, 0);
        chk("kb_hwdata0", HWDATA, 32'h11111111);
        cyc(0, 1, 0, 0, 32'h33333333, 2'b10, 32'h400, 0, 0, 0, 0);
        chk("kb_hwdata1", HWDATA, 32'h22222222);
        chk("kb_hburst", 32'(HBURST), 32'h1);
        cyc(0, 1, 0, 0, 32'h44444444, 2'b11, 32'h404, 0, 0, 0, 0);
        chk("kb_hwdata2", HWDATA, 32'h33333333);
        cyc(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        chk("kb_hwdata3", HWDATA, 32'h44444444);
        chk("kb_wr_req", 32'(wr_req), 32'h0);
        cyc(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);

        // ERROR on beat 2 of an 8-beat read
        cmd(1'b0, 32'h500, 4'd7);
        cyc(0, 1, 0, 0, 0, 2'b10, 32'h500, 0, 0, 0, 0);
        cyc(0, 1, 0, 32'hC0C0C0C0, 0, 2'b11, 32'h504, 0, 0, 0, 0);
        cyc(0, 1, 0, 32'hC1C1C1C1, 0, 2'b11, 32'h508, 1, 32'hC0C0C0C0, 0, 0);
        cyc(0, 0, 1, 32'hEEEEEEEE, 0, 2'b11, 32'h50C, 1, 32'hC1C1C1C1, 0, 0);
        cyc(0, 1, 1, 32'hEEEEEEEE, 0, 2'b00, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1);
        cmd(1'b0, 32'h600, 4'd0);
        cyc(0, 1, 0, 0, 0, 2'b10, 32'h600, 0, 0, 0, 0);
        chk("er_next_hburst", 32'(HBURST), 32'h0);
        cyc(0, 1, 0, 32'h600D600D, 0, 2'b00, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 2'b00, 0, 1, 32'h600D600D, 1, 0);

        // Reset in the middle of a 16-beat write
        cmd(1'b1, 32'h800, 4'd15);
        cyc(0, 1, 0, 0, 32'h80000000, 2'b10, 32'h800, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 32'h80000001, 2'b11, 32'h804, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 32'h80000002, 2'b11, 32'h808, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 32'h80000003, 2'b11, 32'h80C, 0, 0, 0, 0);
        HRESETn = 1'b0;
        #1;
        chk("mr_htrans", 32'(HTRANS), 32'h0);
        chk("mr_haddr", HADDR, 32'h0);
        chk("mr_hwrite", 32'(HWRITE), 32'h0);
        chk("mr_hburst", 32'(HBURST), 32'h0);
        chk("mr_hwdata", HWDATA, 32'h0);
        chk("mr_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("mr_wr_req", 32'(wr_req), 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        cmd(1'b1, 32'h900, 4'd1);
        cyc(0, 1, 0, 0, 32'h90000000, 2'b10, 32'h900, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 32'h90000001, 2'b11, 32'h904, 0, 0, 0, 0);
        chk("mr_new_hwdata", HWDATA, 32'h90000000);
        cyc(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);

        // Back-to-back 2-beat writes with cmd_valid held
        cmd(1'b1, 32'hA00, 4'd1);
        cyc(1, 1, 0, 0, 32'hAAAA0000, 2'b10, 32'hA00, 0, 0, 0, 0);
        cmd_addr = 32'hB00;
        cyc(1, 1, 0, 0, 32'hAAAA0001, 2'b11, 32'hA04, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        chk("bb_cmd_ready_busy", 32'(cmd_ready), 32'h0);
        cyc(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
        chk("bb_cmd_ready_done", 32'(cmd_ready), 32'h1);
        cyc(0, 1, 0, 0, 32'hBBBB0000, 2'b10, 32'hB00, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 32'hBBBB0001, 2'b11, 32'hB04, 0, 0, 0, 0);
        chk("bb_hwdata", HWDATA, 32'hBBBB0000);
        cyc(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        chk("bb_hwdata_last", HWDATA, 32'hBBBB0001);
        cyc(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
